// File: rtl/wb_arbiter.sv
// Writeback arbiter: three per-source result FIFOs (load > branch > alu) that drain
// through one registered register-file write port, with a starvation override for the ALU.

module wb_fifo #(
    parameter int DEPTH = 2,
    parameter int RW    = 6,
    parameter int DW    = 32,
    localparam int EW   = RW + DW,
    localparam int AW   = $clog2(DEPTH),
    localparam int CW   = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic [EW-1:0] din,
    input  logic          pop,
    output logic [EW-1:0] head,
    output logic [CW-1:0] count,
    input  logic [RW-1:0] qreg,
    output logic          hit
);
    logic [DEPTH-1:0][EW-1:0] mem;
    logic [AW-1:0]            rd_ptr, wr_ptr, off;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem    <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)
                count <= count + 1'b1;
            else if (pop && !push)
                count <= count - 1'b1;
        end
    end

    assign head = mem[rd_ptr];

    // A slot is live when its distance from the read pointer is below the fill count.
    always_comb begin
        hit = 1'b0;
        off = '0;
        for (int i = 0; i < DEPTH; i++) begin
            off = AW'(i) - rd_ptr;
            if ((CW'(off) < count) && (mem[i][EW-1 -: RW] == qreg))
                hit = 1'b1;
        end
    end
endmodule

module wb_arbiter #(
    parameter int DEPTH        = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ld_valid,
    input  logic [5:0]  ld_reg,
    input  logic [31:0] ld_data,
    output logic        ld_ready,
    input  logic        br_valid,
    input  logic [5:0]  br_reg,
    input  logic [31:0] br_data,
    output logic        br_ready,
    input  logic        alu_valid,
    input  logic [5:0]  alu_reg,
    input  logic [31:0] alu_data,
    output logic        alu_ready,
    output logic        wb_we,
    output logic [5:0]  wb_reg,
    output logic [31:0] wb_data,
    input  logic [5:0]  pend_reg,
    output logic        pend_hit,
    output logic        idle
);
    localparam int NSRC = 3;
    localparam int RW   = 6;
    localparam int DW   = 32;
    localparam int EW   = RW + DW;
    localparam int CW   = $clog2(DEPTH + 1);
    localparam int SW   = $clog2(STARVE_LIMIT + 1);
    localparam int LD   = 0;
    localparam int BR   = 1;
    localparam int ALU  = 2;

    logic [NSRC-1:0]          src_valid, src_ready, push, pop, nempty, hit;
    logic [NSRC-1:0][EW-1:0]  src_ent, head;
    logic [NSRC-1:0][CW-1:0]  count;
    logic [EW-1:0]            sel_ent;
    logic [SW-1:0]            starve;
    logic                     force_alu;

    assign src_valid = {alu_valid, br_valid, ld_valid};
    assign src_ent   = {{alu_reg, alu_data}, {br_reg, br_data}, {ld_reg, ld_data}};
    assign {alu_ready, br_ready, ld_ready} = src_ready;

    generate
        for (genvar s = 0; s < NSRC; s++) begin : g_src
            assign src_ready[s] = count[s] != CW'(DEPTH);
            assign nempty[s]    = count[s] != '0;
            // reg 0 completes the handshake but is dropped on the floor
            assign push[s]      = src_valid[s] && src_ready[s] && (src_ent[s][EW-1 -: RW] != '0);

            wb_fifo #(.DEPTH(DEPTH), .RW(RW), .DW(DW)) u_fifo (
                .clk   (clk),
                .rst   (rst),
                .push  (push[s]),
                .din   (src_ent[s]),
                .pop   (pop[s]),
                .head  (head[s]),
                .count (count[s]),
                .qreg  (pend_reg),
                .hit   (hit[s])
            );
        end
    endgenerate

    assign force_alu = (starve == SW'(STARVE_LIMIT)) && nempty[ALU];

    always_comb begin
        pop = '0;
        if (force_alu)       pop[ALU] = 1'b1;
        else if (nempty[LD]) pop[LD]  = 1'b1;
        else if (nempty[BR]) pop[BR]  = 1'b1;
        else if (nempty[ALU]) pop[ALU] = 1'b1;
    end

    always_comb begin
        sel_ent = '0;
        for (int s = 0; s < NSRC; s++)
            if (pop[s]) sel_ent = head[s];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wb_we   <= 1'b0;
            wb_reg  <= '0;
            wb_data <= '0;
            starve  <= '0;
        end else begin
            wb_we <= |pop;
            if (|pop)
                {wb_reg, wb_data} <= sel_ent;
            if (!nempty[ALU] || pop[ALU])
                starve <= '0;
            else if (starve != SW'(STARVE_LIMIT))
                starve <= starve + 1'b1;
        end
    end

    assign pend_hit = (pend_reg != '0) && ((|hit) || (wb_we && (wb_reg == pend_reg)));
    assign idle     = !(|nempty) && !wb_we;
endmodule
